snoop_bus_arbiter: RTL and testbench
====================================

SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default types::NUM_CPUS, number of requesting caches (2..16).
REQ-002 Parameter FIFO_DEPTH, default 2, request-queue entries per requester (power of two, >=2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester push strobe.
REQ-006 req_msg  input  NUM_REQ x bus_msg_t  request; valid and source fields ignored.
REQ-007 req_ready  output  NUM_REQ  queue not full.
REQ-008 bus_out  output  bus_msg_t  snoop broadcast; valid high exactly one cycle per granted transaction.
REQ-009 bus_done  input  1  responder (xbar/memory) signals granted transaction complete.
REQ-010 busy  output  1  a transaction is outstanding.
REQ-011 grant_id  output  $clog2(NUM_REQ)  index of last granted requester.

Function
REQ-012 Push into queue i when req_valid[i] && req_ready[i]; req_ready[i] = queue i not full (no same-cycle pass-through when full).
REQ-013 FSM states IDLE, BCAST, WAIT; IDLE->BCAST when any queue non-empty; BCAST->WAIT unconditionally; WAIT->IDLE on bus_done.
REQ-014 In BCAST: bus_out = head of winning queue, valid=1, source=winner index; winner popped same cycle.
REQ-015 bus_out.valid=0 and bus_out.bus_tx=BusIdle in IDLE and WAIT.
REQ-016 Winner = first non-empty queue at or after rr_ptr (wrapping mod NUM_REQ); rr_ptr <= winner+1 mod NUM_REQ on grant.
REQ-017 Grant decision made on IDLE-cycle queue state; pushes that cycle are not visible until next cycle.
REQ-018 bus_done sampled only in WAIT; asserted in IDLE/BCAST is ignored.
REQ-019 busy = 1 in BCAST and WAIT; minimum grant-to-grant spacing 3 cycles (BCAST, WAIT with done, IDLE).
REQ-020 Queue pointers $clog2(FIFO_DEPTH)+1 bits, wrap naturally; full when MSBs differ and LSBs equal.
REQ-021 Push and pop on the same queue in one cycle: count unchanged, order preserved.

Reset
REQ-022 On rst_n low: FSM=IDLE, rr_ptr=0, all queues empty, grant_id=0, busy=0, bus_out all-zero with bus_tx=BusIdle, req_ready all 1 after release.
REQ-023 Reset mid-transaction discards queued and outstanding requests; no broadcast until a new push.

Configuration
REQ-024 Macro SNOOP_BUS_PUTM_PRIORITY_EN: when defined, any queue whose head is BusPutM wins over GetS/GetM heads (round-robin among PutM heads, same rr_ptr); when undefined, bus_tx has no effect on arbitration.
REQ-025 rr_ptr update rule identical in both builds.

Structure
REQ-026 arb_state_t (IDLE/BCAST/WAIT) and default FIFO_DEPTH constant belong in package types; bus_msg_t, bus_tx_t reused unchanged.
REQ-027 One sub-module req_fifo (parametrised width/depth, push/pop/full/empty), instantiated NUM_REQ times.

Verification
REQ-028 Reset, CPU1 pushes BusGetS addr 0x15 -> 2 cycles later bus_out valid, source=1, addr=0x15; busy=1 until bus_done.
REQ-029 All 4 CPUs push same cycle, bus_done 1 cycle after each BCAST -> grants 0,1,2,3 in order, 3-cycle spacing.
REQ-030 CPU2 pushes 3 requests, FIFO_DEPTH=2 -> req_ready[2]=0 after 2nd push; 3rd accepted only after first grant.
REQ-031 With SNOOP_BUS_PUTM_PRIORITY_EN: CPU0 GetM, CPU3 PutM pending, rr_ptr=0 -> CPU3 granted first; without macro CPU0 first.
REQ-032 rst_n low during WAIT with 2 queued -> bus_out.valid stays 0, busy=0 after release, no stale broadcast.
REQ-033 bus_done pulsed in IDLE -> ignored; next transaction still waits for its own bus_done.

Source files
------------

// File: rtl/snoop_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : types
// Description : Shared snoop-bus message types, arbiter FSM state encoding
//               and default sizing constants for the snoop bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package types;

  // Number of caches on the snoop bus in the default system build
  localparam int NUM_CPUS       = 4;
  // Default per-requester request queue depth
  localparam int DEF_FIFO_DEPTH = 2;

  // Snoop bus transaction kinds; BusIdle is the all-zero encoding
  typedef enum logic [1:0] {
    BusIdle = 2'd0,
    BusGetS = 2'd1,
    BusGetM = 2'd2,
    BusPutM = 2'd3
  } bus_tx_t;

  // Snoop bus message as seen by every cache and the responder
  typedef struct packed {
    logic        valid;
    bus_tx_t     bus_tx;
    logic [3:0]  source;
    logic [31:0] addr;
  } bus_msg_t;

  // Arbiter transaction FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BCAST = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/snoop_bus_arbiter_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : req_fifo
// Description : Per-requester request queue. Power-of-two depth, pointers
//               one bit wider than the address so full/empty are told apart
//               by the wrap bit. Push is refused when full, pop when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; a simultaneous push and pop moves both and keeps the count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers, cleared to empty on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care while the slot is not occupied
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : snoop_bus_arbiter
// Description : Round-robin arbiter for a snooping bus. Each cache has a small
//               request queue; one transaction at a time is broadcast for a
//               single cycle, then the arbiter waits for the responder's
//               bus_done before granting again.
//               Optional build macro SNOOP_BUS_PUTM_PRIORITY_EN: queues whose
//               head is BusPutM win over GetS/GetM heads (round-robin among
//               themselves using the same pointer).
// Revision    : 1.0 - initial release
// ============================================================================
module snoop_bus_arbiter
  import types::*;
#(
  parameter int NUM_REQ    = NUM_CPUS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  bus_msg_t                   req_msg [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_ready,
  output bus_msg_t                   bus_out,
  input  logic                       bus_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int             IW       = $clog2(NUM_REQ);
  localparam int             MW       = $bits(bus_msg_t);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_REQ - 1);

  logic [NUM_REQ-1:0] full;
  logic [NUM_REQ-1:0] empty;
  logic [NUM_REQ-1:0] pop;
  bus_msg_t           head [NUM_REQ];
  logic [NUM_REQ-1:0] cand;

  arb_state_t    state_q;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] grant_id_q;
  logic          busy_q;
  bus_msg_t      bus_out_q;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] rr_next;
  bus_msg_t      bcast_msg;

  // One request queue per cache
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    req_fifo #(
      .WIDTH (MW),
      .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (req_valid[i]),
      .data_i  (req_msg[i]),
      .pop_i   (pop[i]),
      .data_o  (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  assign req_ready = ~full;

`ifdef SNOOP_BUS_PUTM_PRIORITY_EN
  logic [NUM_REQ-1:0] putm_head;

  // Writebacks first: restrict candidates to PutM heads whenever any exist
  always_comb begin
    putm_head = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      putm_head[i] = !empty[i] && (head[i].bus_tx == BusPutM);
    end
    cand = (|putm_head) ? putm_head : ~empty;
  end
`else
  assign cand = ~empty;
`endif

  // Round-robin search: first candidate at or after rr_ptr, wrapping
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  assign rr_next = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;

  // Broadcast image of the winning head, stamped with valid and source
  always_comb begin
    bcast_msg        = head[win_idx];
    bcast_msg.valid  = 1'b1;
    bcast_msg.source = 4'(win_idx);
  end

  // Winner is popped at the end of the broadcast cycle; its head is stable
  // until then because only a pop can change a queue head
  always_comb begin
    pop = '0;
    if (state_q == BCAST) pop[grant_id_q] = 1'b1;
  end

  // Transaction FSM with registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      bus_out_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q    <= BCAST;
            bus_out_q  <= bcast_msg;
            grant_id_q <= win_idx;
            rr_ptr_q   <= rr_next;
            busy_q     <= 1'b1;
          end
        end
        BCAST: begin
          state_q   <= WAIT;
          bus_out_q <= '0;
        end
        WAIT: begin
          if (bus_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          bus_out_q <= '0;
        end
      endcase
    end
  end

  assign bus_out  = bus_out_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_snoop_bus_arbiter
// Description : Directed self-checking bench for snoop_bus_arbiter
//               (4 requesters, depth-2 queues).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snoop_bus_arbiter;
  import types::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  bus_msg_t       req_msg [N];
  logic [N-1:0]   req_ready;
  bus_msg_t       bus_out;
  logic           bus_done = 1'b0;
  logic           busy;
  logic [1:0]     grant_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  snoop_bus_arbiter #(
    .NUM_REQ    (N),
    .FIFO_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_msg   (req_msg),
    .req_ready (req_ready),
    .bus_out   (bus_out),
    .bus_done  (bus_done),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_msg(input int i, input bus_tx_t tx, input logic [31:0] a);
    req_msg[i] = '{1'b0, tx, 4'd0, a};
  endtask

  task automatic check_bcast(input string tag, input int src, input logic [31:0] a,
                             input bus_tx_t tx);
    chk({tag, " valid"},  64'(bus_out.valid),  64'd1);
    chk({tag, " source"}, 64'(bus_out.source), 64'(src));
    chk({tag, " addr"},   64'(bus_out.addr),   64'(a));
    chk({tag, " tx"},     64'(bus_out.bus_tx), 64'(tx));
    chk({tag, " grant"},  64'(grant_id),       64'(src));
    chk({tag, " busy"},   64'(busy),           64'd1);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, " valid0"}, 64'(bus_out.valid),  64'd0);
    chk({tag, " txidle"}, 64'(bus_out.bus_tx), 64'(BusIdle));
  endtask

  task automatic finish_txn();
    bus_done = 1'b1;
    tick();
    bus_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int first_src;
    int second_src;
    for (int i = 0; i < N; i++) set_msg(i, BusIdle, 32'h0);

    // Reset state
    tick();
    tick();
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst bus_out", 64'(bus_out), 64'd0);
    chk("rst grant", 64'(grant_id), 64'd0);
    rst_n = 1'b1;
    chk("rst ready", 64'(req_ready), 64'hF);

    // Single GetS from CPU1, broadcast two cycles after the push cycle
    set_msg(1, BusGetS, 32'h15);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    check_quiet("t1 idle");
    chk("t1 idle busy", 64'(busy), 64'd0);
    tick();
    check_bcast("t1", 1, 32'h15, BusGetS);
    tick();
    check_quiet("t1 wait");
    chk("t1 wait busy", 64'(busy), 64'd1);
    tick();
    tick();
    chk("t1 hold busy", 64'(busy), 64'd1);
    finish_txn();
    chk("t1 done busy", 64'(busy), 64'd0);

    // bus_done held through IDLE and BCAST must not end the transaction
    bus_done = 1'b1;
    set_msg(0, BusGetM, 32'h20);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    chk("t2 idle busy", 64'(busy), 64'd0);
    tick();
    check_bcast("t2", 0, 32'h20, BusGetM);
    tick();
    bus_done = 1'b0;
    chk("t2 wait busy", 64'(busy), 64'd1);
    tick();
    chk("t2 own done", 64'(busy), 64'd1);
    finish_txn();
    chk("t2 done busy", 64'(busy), 64'd0);

    // All four push together: grants 0,1,2,3 exactly three cycles apart
    do_reset();
    for (int i = 0; i < N; i++) set_msg(i, BusGetS, 32'h100 + 32'(i));
    req_valid = 4'hF;
    tick();
    req_valid = '0;
    check_quiet("t3 idle");
    for (int g = 0; g < N; g++) begin
      tick();
      check_bcast($sformatf("t3 g%0d", g), g, 32'h100 + 32'(g), BusGetS);
      tick();
      check_quiet($sformatf("t3 w%0d", g));
      finish_txn();
      chk($sformatf("t3 i%0d busy", g), 64'(busy), 64'd0);
      check_quiet($sformatf("t3 i%0d", g));
    end

    // Backpressure on CPU2 with a depth-2 queue
    set_msg(2, BusGetM, 32'h200);
    req_valid = 4'b0100;
    chk("t4 ready0", 64'(req_ready[2]), 64'd1);
    tick();
    set_msg(2, BusGetM, 32'h201);
    tick();
    check_bcast("t4 b0", 2, 32'h200, BusGetM);
    chk("t4 full", 64'(req_ready[2]), 64'd0);
    set_msg(2, BusGetM, 32'h202);
    tick();
    chk("t4 ready after pop", 64'(req_ready[2]), 64'd1);
    check_quiet("t4 wait");
    tick();
    req_valid = '0;
    chk("t4 full again", 64'(req_ready[2]), 64'd0);
    finish_txn();
    tick();
    check_bcast("t4 b1", 2, 32'h201, BusGetM);
    tick();
    finish_txn();
    tick();
    check_bcast("t4 b2", 2, 32'h202, BusGetM);
    tick();
    finish_txn();
    tick();
    check_quiet("t4 drained");
    chk("t4 drained busy", 64'(busy), 64'd0);

    // Push on the same cycle the head is popped
    set_msg(1, BusGetS, 32'h300);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    check_bcast("t5 b0", 1, 32'h300, BusGetS);
    set_msg(1, BusGetS, 32'h301);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    chk("t5 ready", 64'(req_ready[1]), 64'd1);
    check_quiet("t5 wait");
    finish_txn();
    tick();
    check_bcast("t5 b1", 1, 32'h301, BusGetS);
    tick();
    finish_txn();
    tick();
    tick();
    check_quiet("t5 empty");

    // CPU0 GetM vs CPU3 PutM with rr_ptr at 0
`ifdef SNOOP_BUS_PUTM_PRIORITY_EN
    first_src  = 3;
    second_src = 0;
`else
    first_src  = 0;
    second_src = 3;
`endif
    do_reset();
    set_msg(0, BusGetM, 32'h400);
    set_msg(3, BusPutM, 32'h403);
    req_valid = 4'b1001;
    tick();
    req_valid = '0;
    tick();
    check_bcast("t6 first", first_src, (first_src == 3) ? 32'h403 : 32'h400,
                (first_src == 3) ? BusPutM : BusGetM);
    tick();
    finish_txn();
    tick();
    check_bcast("t6 second", second_src, (second_src == 3) ? 32'h403 : 32'h400,
                (second_src == 3) ? BusPutM : BusGetM);
    tick();
    finish_txn();

    // Reset during WAIT with two requests still queued
    do_reset();
    for (int i = 0; i < 3; i++) set_msg(i, BusGetS, 32'h600 + 32'(i));
    req_valid = 4'b0111;
    tick();
    req_valid = '0;
    tick();
    check_bcast("t7 b0", 0, 32'h600, BusGetS);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t7 async busy", 64'(busy), 64'd0);
    check_quiet("t7 async");
    tick();
    tick();
    rst_n = 1'b1;
    chk("t7 ready", 64'(req_ready), 64'hF);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t7 stale%0d", k), 64'(bus_out.valid), 64'd0);
      chk($sformatf("t7 busy%0d", k), 64'(busy), 64'd0);
    end
    set_msg(2, BusGetS, 32'h700);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    check_bcast("t7 new", 2, 32'h700, BusGetS);
    tick();
    finish_txn();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
